// File: rtl/mac2x2_acc.sv
// ============================================================================
// Module   : mac2x2_acc (with helper mul2x2)
// Brief    : Sums N consecutive 2x2-bit products into an ACC_W-bit total.
//            Operand pairs arrive on a valid/ready port, and the finished
//            total leaves on a second valid/ready port.
//            Optional build macro: MAC2X2_SATURATE_EN. When it is defined,
//            the accumulator clamps to all-ones on overflow instead of
//            wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Gate-level 2x2 unsigned multiplier (product range 0..9).
module mul2x2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);
  logic w_a0b0, w_a1b0, w_a0b1, w_a1b1, w_c1;

  assign w_a0b0 = a_i[0] & b_i[0];
  assign w_a1b0 = a_i[1] & b_i[0];
  assign w_a0b1 = a_i[0] & b_i[1];
  assign w_a1b1 = a_i[1] & b_i[1];
  assign w_c1   = w_a1b0 & w_a0b1;

  assign p_o[0] = w_a0b0;
  assign p_o[1] = w_a1b0 ^ w_a0b1;
  assign p_o[2] = w_a1b1 ^ w_c1;
  assign p_o[3] = w_a1b1 & w_c1;
endmodule

module mac2x2_acc #(
  parameter int N     = 4,
  parameter int ACC_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);
  localparam int             CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             oovf_q, oovf_d;

  logic [3:0]       w_prod;
  logic [ACC_W:0]   w_add_full;
  logic             w_carry;
  logic [ACC_W-1:0] w_add_res;
  logic             w_accept;

  mul2x2 u_mul (
    .a_i (a),
    .b_i (b),
    .p_o (w_prod)
  );

  // One extra bit on the adder captures the carry out for the overflow flag.
  assign w_add_full = {1'b0, acc_q} + (ACC_W + 1)'(w_prod);
  assign w_carry    = w_add_full[ACC_W];

`ifdef MAC2X2_SATURATE_EN
  // Once clamped, acc stays at all-ones: any non-zero product carries again.
  assign w_add_res = w_carry ? {ACC_W{1'b1}} : w_add_full[ACC_W-1:0];
`else
  assign w_add_res = w_add_full[ACC_W-1:0];
`endif

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign w_accept  = in_valid & in_ready;
  assign out_sum   = sum_q;
  assign out_ovf   = oovf_q;

  // Next-state logic: accumulate beats, hand the total off on the last beat.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    oovf_d  = oovf_q;
    case (state_q)
      ST_ACC: begin
        if (w_accept) begin
          if (cnt_q == CNT_LAST) begin
            sum_d   = w_add_res;
            oovf_d  = ovf_q | w_carry;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ST_OUT;
          end else begin
            acc_d = w_add_res;
            ovf_d = ovf_q | w_carry;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // State registers, cleared asynchronously so a reset drops any partial burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      oovf_q  <= oovf_d;
    end
  end

endmodule

`default_nettype wire
